// File: rtl/fpu_rr_scheduler.sv
// Round-robin scheduler sharing one single-precision FPU datapath between N_REQ requesters.
// One operation in flight; result returned with the requester id on a valid/ready channel.
module fpu_rr_scheduler #(
   parameter int N_REQ       = 4,
   parameter int IDW         = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
   parameter int FPU_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   input  logic [2*N_REQ-1:0]    req_opcode,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [31:0]           rsp_result,
   output logic [31:0]           fpu_a,
   output logic [31:0]           fpu_b,
   output logic [1:0]            fpu_opcode,
   input  logic [31:0]           fpu_outp,
   output logic                  busy
);

   localparam int CW = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q;
   logic [IDW-1:0]  last_q;
   logic [CW-1:0]   cnt_q;
   logic            rsp_valid_q;
   logic [IDW-1:0]  rsp_id_q;
   logic [31:0]     rsp_result_q;
   logic [31:0]     fpu_a_q;
   logic [31:0]     fpu_b_q;
   logic [1:0]      fpu_op_q;

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  scan_idx;
   logic            handshake;

   // Scan starts just past the last winner, so the previous winner has lowest priority.
   // NOTE: every variable assigned in always_comb gets a default first; otherwise a latch is inferred.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = IDW'((int'(last_q) + k) % N_REQ);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   assign req_ready = (!rst && state_q == S_IDLE && grant_found)
                      ? (N_REQ'(1) << grant_idx) : '0;
   assign handshake = |(req_valid & req_ready);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_q       <= IDW'(N_REQ - 1);
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         fpu_a_q      <= '0;
         fpu_b_q      <= '0;
         fpu_op_q     <= 2'b00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (handshake) begin
                  fpu_a_q  <= req_a[32*grant_idx +: 32];
                  fpu_b_q  <= req_b[32*grant_idx +: 32];
                  fpu_op_q <= req_opcode[2*grant_idx +: 2];
                  rsp_id_q <= grant_idx;
                  last_q   <= grant_idx;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= CW'(FPU_LATENCY - 1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  rsp_result_q <= fpu_outp;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign fpu_a      = fpu_a_q;
   assign fpu_b      = fpu_b_q;
   assign fpu_opcode = fpu_op_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Self-checking bench for fpu_rr_scheduler: directed scenarios plus randomized traffic
// against a round-robin reference model; the FPU stub returns A^B after FPU_LATENCY posedges.
module tb_fpu_rr_scheduler;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int LAT = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic [2*N-1:0]    req_opcode;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_result;
   logic [31:0]       fpu_a;
   logic [31:0]       fpu_b;
   logic [1:0]        fpu_opcode;
   logic [31:0]       fpu_outp;
   logic              busy;

   int checks   = 0;
   int failures = 0;
   int last_m   = N - 1;

   always #5 clk = ~clk;

   fpu_rr_scheduler #(
      .N_REQ       (N),
      .IDW         (IDW),
      .FPU_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_opcode (req_opcode),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_opcode (fpu_opcode),
      .fpu_outp   (fpu_outp),
      .busy       (busy)
   );

   // FPU stub: registered A^B, LAT stages deep.
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= fpu_a ^ fpu_b;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign fpu_outp = pipe[LAT-1];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference arbiter: first asserted requester after the last winner, cyclically.
   function automatic int pick(input logic [N-1:0] v, input int last);
      int i;
      for (int k = 1; k <= N; k++) begin
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_ops;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32]    = $urandom;
         req_b[32*i +: 32]    = $urandom;
         req_opcode[2*i +: 2] = 2'($urandom);
      end
   endtask

   task automatic do_reset;
      rst       = 1'b1;
      req_valid = '0;
      tick;
      rst       = 1'b0;
      last_m    = N - 1;
   endtask

   // One complete transaction with exact cycle timing; hold = cycles of rsp_ready=0 in RESP.
   task automatic run_txn(input logic [N-1:0] mask, input int hold, input string tag);
      int          g;
      logic [31:0] ea;
      logic [31:0] eb;
      logic [1:0]  eo;
      req_valid = mask;
      rsp_ready = (hold == 0);
      #1;
      g = pick(mask, last_m);
      if (g < 0) begin
         checks++;
         failures++;
         $error("FAIL %s/mask observed=%h expected=nonzero", tag, mask);
         return;
      end
      check({tag, "/ready"}, 32'(req_ready), 32'(1 << g));
      check({tag, "/busy_idle"}, 32'(busy), 32'(0));
      ea = req_a[32*g +: 32];
      eb = req_b[32*g +: 32];
      eo = req_opcode[2*g +: 2];
      tick;
      last_m = g;
      req_valid = N'($urandom);
      randomize_ops();
      check({tag, "/fpu_a"}, fpu_a, ea);
      check({tag, "/fpu_b"}, fpu_b, eb);
      check({tag, "/fpu_op"}, 32'(fpu_opcode), 32'(eo));
      check({tag, "/busy"}, 32'(busy), 32'(1));
      for (int i = 0; i <= LAT; i++) begin
         tick;
         check({tag, "/ready_busy"}, 32'(req_ready), 32'(0));
         if (i < LAT) begin
            check({tag, "/early_valid"}, 32'(rsp_valid), 32'(0));
         end else begin
            check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(1));
            check({tag, "/rsp_id"}, 32'(rsp_id), 32'(g));
            check({tag, "/rsp_result"}, rsp_result, ea ^ eb);
         end
      end
      for (int h = 0; h < hold; h++) begin
         tick;
         check({tag, "/hold_valid"}, 32'(rsp_valid), 32'(1));
         check({tag, "/hold_id"}, 32'(rsp_id), 32'(g));
         check({tag, "/hold_result"}, rsp_result, ea ^ eb);
         check({tag, "/hold_ready"}, 32'(req_ready), 32'(0));
         check({tag, "/hold_fpu_a"}, fpu_a, ea);
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      tick;
      check({tag, "/done_valid"}, 32'(rsp_valid), 32'(0));
      check({tag, "/done_busy"}, 32'(busy), 32'(0));
      check({tag, "/idle_fpu_a"}, fpu_a, ea);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '1;
      rsp_ready  = 1'b0;
      req_a      = '0;
      req_b      = '0;
      req_opcode = '0;
      randomize_ops();

      // Reset with all requesters asserting.
      tick;
      tick;
      check("rst/req_ready", 32'(req_ready), 32'(0));
      check("rst/rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst/busy", 32'(busy), 32'(0));
      check("rst/fpu_opcode", 32'(fpu_opcode), 32'(0));
      check("rst/fpu_a", fpu_a, 32'h0);
      check("rst/fpu_b", fpu_b, 32'h0);
      check("rst/rsp_id", 32'(rsp_id), 32'(0));
      check("rst/rsp_result", rsp_result, 32'h0);
      req_valid = '0;
      rst       = 1'b0;
      last_m    = N - 1;
      tick;

      // Single op from requester 2.
      req_a[64 +: 32]   = 32'h3F800000;
      req_b[64 +: 32]   = 32'h40000000;
      req_opcode[4 +: 2] = 2'b11;
      run_txn(4'b0100, 0, "single");
      check("single/const_result", rsp_result, 32'h7F800000);

      // Round robin with all requesters held.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         randomize_ops();
         run_txn(4'b1111, 0, "rr");
      end

      // Backpressure for 10 cycles.
      randomize_ops();
      run_txn(4'b0010, 10, "bp");

      // Reset while WAIT: no response, pointer returns to its reset value.
      randomize_ops();
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      tick;
      req_valid = '0;
      tick;
      rst = 1'b1;
      tick;
      rst    = 1'b0;
      last_m = N - 1;
      for (int i = 0; i < 4; i++) begin
         check("midrst/rsp_valid", 32'(rsp_valid), 32'(0));
         check("midrst/busy", 32'(busy), 32'(0));
         tick;
      end
      randomize_ops();
      run_txn(4'b1111, 0, "midrst_next");

      // Skip and wrap.
      randomize_ops();
      run_txn(4'b1000, 0, "skip_to3");
      run_txn(4'b1010, 0, "skip_a");
      run_txn(4'b1010, 0, "skip_b");
      run_txn(4'b0001, 0, "wrap");

      // Randomized traffic with random backpressure.
      for (int t = 0; t < 40; t++) begin
         randomize_ops();
         run_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
